// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, data width and bit-period helpers.
// Used by both the transmit and receive sides of the keyboard link.
package uart_pkg;

  localparam int C_DATA_W = 8;

  localparam logic [2:0] sIdle   = 3'd0;
  localparam logic [2:0] sStart  = 3'd1;
  localparam logic [2:0] sData   = 3'd2;
  localparam logic [2:0] sParity = 3'd3;
  localparam logic [2:0] sStop   = 3'd4;

  // Bit period in clock cycles; integer division truncates toward zero.
  function automatic int bitPeriod(input int clkFrq, input int baud);
    return clkFrq / baud;
  endfunction

  function automatic int cntWidth(input int period);
    return (period < 2) ? 1 : $clog2(period);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: tick is high for one cycle when the count reaches C_BIT-1.
// clear holds the count at zero; the counter never runs past C_BIT-1.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int C_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int C_W = cntWidth(C_BIT);
  localparam logic [C_W-1:0] C_LAST = C_W'(C_BIT - 1);

  logic [C_W-1:0] cnt_q;
  logic [C_W-1:0] cnt_d;

  assign tick = (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q + C_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, valid/ready byte input, all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int C_CLK_FRQ = 100_000_000,
  parameter int C_BAUD    = 115_200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                UART_valid,
  input  logic [C_DATA_W-1:0] UART_msg,
  output logic                UART_ready,
  output logic                UART_tx,
  output logic                UART_done
);

  localparam int C_BIT = bitPeriod(C_CLK_FRQ, C_BAUD);
  localparam int C_BW  = $clog2(C_DATA_W);
  localparam logic [C_BW-1:0] C_LAST_BIT = C_BW'(C_DATA_W - 1);

  logic [2:0]          state_q, state_d;
  logic [C_BW-1:0]     bitCnt_q, bitCnt_d;
  logic [C_DATA_W-1:0] shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic tick;
  logic baudClear;

  // The counter idles at zero, so the first bit after a transfer is full length.
  assign baudClear = (state_q == sIdle);

  uart_baud_gen #(
    .C_BIT(C_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baudClear),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      sIdle: begin
        if (UART_valid && ready_q) begin
          state_d  = sStart;
          shift_d  = UART_msg;
          bitCnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^UART_msg;
`endif
        end
      end
      sStart: if (tick) state_d = sData;
      sData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bitCnt_q == C_LAST_BIT) begin
            bitCnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = sParity;
`else
            state_d  = sStop;
`endif
          end else begin
            bitCnt_d = bitCnt_q + C_BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      sParity: if (tick) state_d = sStop;
`endif
      sStop: begin
        if (tick) begin
          state_d = sIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = sIdle;
    endcase

    // Outputs follow the next state so they change on the same edge as the FSM.
    case (state_d)
      sStart:  tx_d = 1'b0;
      sData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      sParity: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == sIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= sIdle;
      bitCnt_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign UART_tx    = tx_q;
  assign UART_ready = ready_q;
  assign UART_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at C_BIT = 10; the expected line level per cycle
// comes from a frame model built from slot arithmetic (start, data LSB first, [parity], stop).
module tb_uart_tx;

  localparam int C_CLK_FRQ = 1_000_000;
  localparam int C_BAUD    = 100_000;
  localparam int C_BIT     = C_CLK_FRQ / C_BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int C_SLOTS = 11;
`else
  localparam int C_SLOTS = 10;
`endif
  localparam int C_FRAME = C_SLOTS * C_BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       UART_valid = 1'b0;
  logic [7:0] UART_msg = 8'h00;
  logic       UART_ready;
  logic       UART_tx;
  logic       UART_done;

  int checkCount = 0;
  int passCount  = 0;
  int cycleNo    = 0;
  int prevStart  = 0;

  uart_tx #(
    .C_CLK_FRQ(C_CLK_FRQ),
    .C_BAUD   (C_BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .UART_valid(UART_valid),
    .UART_msg  (UART_msg),
    .UART_ready(UART_ready),
    .UART_tx   (UART_tx),
    .UART_done (UART_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Line level k cycles after the transfer edge (k = 1 is the first start-bit cycle).
  function automatic logic modelLine(input logic [7:0] b, input int k);
    int slot;
    if (k < 1 || k > C_FRAME) return 1'b1;
    slot = (k - 1) / C_BIT;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
  endtask

  task automatic checkInt(input string tag, input int observed, input int expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    checkOutput("ready before offer", UART_ready, 1'b1);
    UART_valid = 1'b1;
    UART_msg   = b;
  endtask

  // Offers b and follows the whole frame plus the first idle cycle.
  task automatic sendAndCheck(input logic [7:0] b, input logic [7:0] altMsg,
                              input int pulseAt, input bit holdValid, input bit checkGap);
    applyStimulus(b);
    for (int k = 1; k <= C_FRAME + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (checkGap) checkInt("start spacing", cycleNo - prevStart, C_FRAME + 1);
        prevStart = cycleNo;
        if (!holdValid) UART_valid = 1'b0;
        UART_msg = altMsg;
      end
      if (pulseAt != 0 && k == pulseAt) begin
        UART_valid = 1'b1;
        UART_msg   = 8'hEE;
      end
      if (pulseAt != 0 && k == pulseAt + 1) UART_valid = 1'b0;
      checkOutput($sformatf("tx %02h k=%0d", b, k), UART_tx, modelLine(b, k));
      if (k <= C_FRAME) begin
        checkOutput($sformatf("ready %02h k=%0d", b, k), UART_ready, 1'b0);
        checkOutput($sformatf("done %02h k=%0d", b, k), UART_done, 1'b0);
      end else begin
        checkOutput($sformatf("ready end %02h", b), UART_ready, 1'b1);
        checkOutput($sformatf("done end %02h", b), UART_done, 1'b1);
      end
    end
  endtask

  task automatic idleCheck(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s tx", tag), UART_tx, 1'b1);
      checkOutput($sformatf("%s ready", tag), UART_ready, 1'b1);
      checkOutput($sformatf("%s done", tag), UART_done, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] ra;

    repeat (2) @(negedge clk);
    checkOutput("reset tx", UART_tx, 1'b1);
    checkOutput("reset ready", UART_ready, 1'b1);
    checkOutput("reset done", UART_done, 1'b0);
    rst = 1'b0;
    idleCheck(3, "post reset");

    $display("[TB] single byte A5");
    sendAndCheck(8'hA5, 8'hA5, 0, 1'b0, 1'b0);
    idleCheck(2, "after A5");

    $display("[TB] back-to-back 00 then FF");
    sendAndCheck(8'h00, 8'h00, 0, 1'b1, 1'b0);
    sendAndCheck(8'hFF, 8'hFF, 0, 1'b0, 1'b1);
    idleCheck(2, "after FF");

    $display("[TB] msg change mid-frame");
    sendAndCheck(8'h81, 8'h3C, 0, 1'b0, 1'b0);
    idleCheck(2, "after 81");

    $display("[TB] valid pulse while busy");
    sendAndCheck(8'h5A, 8'h5A, 35, 1'b0, 1'b0);
    idleCheck(15, "no second frame");

    $display("[TB] reset mid-frame");
    applyStimulus(8'hC3);
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      if (k == 1) UART_valid = 1'b0;
      checkOutput($sformatf("tx C3 k=%0d", k), UART_tx, modelLine(8'hC3, k));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort tx", UART_tx, 1'b1);
    checkOutput("abort ready", UART_ready, 1'b1);
    checkOutput("abort done", UART_done, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("in reset done", UART_done, 1'b0);
      checkOutput("in reset tx", UART_tx, 1'b1);
    end
    rst = 1'b0;
    sendAndCheck(8'h55, 8'h55, 0, 1'b0, 1'b0);
    idleCheck(2, "after 55");

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity frames");
    sendAndCheck(8'h07, 8'h07, 0, 1'b0, 1'b0);
    sendAndCheck(8'h03, 8'h03, 0, 1'b0, 1'b0);
    idleCheck(2, "after parity");
`endif

    $display("[TB] random bytes");
    for (int n = 0; n < 4; n++) begin
      rb = 8'($urandom_range(0, 255));
      ra = 8'($urandom);
      sendAndCheck(rb, ra, 0, 1'b0, 1'b0);
      idleCheck(int'($urandom_range(1, 4)), "random gap");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
